// File: rtl/imem_noc_router_1ton_pkg.sv
// Shared types and constants for the instruction-memory NoC router.
package imem_noc_router_1ton_pkg;

  typedef struct packed {
    logic [31:0] req_addr;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] resp_data;
    logic        resp_err;
    logic        resp_last;
  } mem_resp_t;

  localparam int IMEM_NOC_OST_DEPTH = 4;

  // Address-space tags (addr[31:28]) of the slaves on the IFU memory fabric.
  localparam logic [3:0] TAG_ROM    = 4'h0;
  localparam logic [3:0] TAG_SRAM   = 4'h1;
  localparam logic [3:0] TAG_PERIPH = 4'h2;
  localparam logic [3:0] TAG_BUS    = 4'h3;

  // Slice i holds the tag of slave i.
  localparam logic [15:0] DEC_TAG_VAL_DFLT = {TAG_BUS, TAG_PERIPH, TAG_SRAM, TAG_ROM};

endpackage

// File: rtl/imem_noc_router_1ton_tid_fifo.sv
// Ordering FIFO of target IDs; head is the slave whose response is due next.
module imem_noc_router_1ton_tid_fifo
  import imem_noc_router_1ton_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;

  // Pointers wrap at DEPTH explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head  = mem[rd_ptr];
  assign cnt   = cnt_q;
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

  // Storage, pointers and occupancy; a push and pop together leave cnt unchanged.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
      assert (!(push && full && !pop));
      assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/imem_noc_router_1ton.sv
// 1-master to SLV_NUM-slave instruction-memory router with in-order responses.
module imem_noc_router_1ton
  import imem_noc_router_1ton_pkg::*;
#(
  parameter int SLV_NUM   = 4,
  parameter int OST_DEPTH = IMEM_NOC_OST_DEPTH,
  parameter int DEC_TAG_H = 31,
  parameter int DEC_TAG_L = 28,
  parameter logic [SLV_NUM*(DEC_TAG_H-DEC_TAG_L+1)-1:0] DEC_TAG_VAL = DEC_TAG_VAL_DFLT,
  parameter int DFLT_SLV  = SLV_NUM - 1,
  localparam int SLV_IDX_W = $clog2(SLV_NUM),
  localparam int CNT_W     = $clog2(OST_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       mn_req_valid,
  output logic                       mn_req_ready,
  input  mem_req_t                   mn_req,
  output logic                       mn_resp_valid,
  input  logic                       mn_resp_ready,
  output mem_resp_t                  mn_resp,
  output logic [SLV_NUM-1:0]         sn_req_valid,
  input  logic [SLV_NUM-1:0]         sn_req_ready,
  output mem_req_t [SLV_NUM-1:0]     sn_req,
  input  logic [SLV_NUM-1:0]         sn_resp_valid,
  output logic [SLV_NUM-1:0]         sn_resp_ready,
  input  mem_resp_t [SLV_NUM-1:0]    sn_resp,
  output logic [SLV_IDX_W-1:0]       sn_tid,
  output logic [CNT_W-1:0]           ost_cnt
);

  localparam int DEC_TAG_W = DEC_TAG_H - DEC_TAG_L + 1;

  logic [DEC_TAG_W-1:0] req_tag;
  logic [SLV_IDX_W-1:0] tid;
  logic [SLV_IDX_W-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 full_blk;

  assign req_tag = mn_req.req_addr[DEC_TAG_H:DEC_TAG_L];
  assign sn_tid  = tid;

  // Lowest-index matching tag wins; unmatched addresses go to the default slave.
  always_comb begin
    tid = SLV_IDX_W'(DFLT_SLV);
    for (int i = SLV_NUM - 1; i >= 0; i--) begin
      if (DEC_TAG_VAL[i*DEC_TAG_W +: DEC_TAG_W] == req_tag) tid = SLV_IDX_W'(i);
    end
  end

  // A retiring transaction frees its slot in the same cycle, so full only blocks without a pop.
  assign pop      = mn_resp_valid & mn_resp_ready & mn_resp.resp_last;
  assign full_blk = full & ~pop;
  assign push     = mn_req_valid & mn_req_ready;

  // Request mux: request broadcast to all slaves, valid/ready steered by the decoded target.
  always_comb begin
    sn_req_valid      = '0;
    sn_req_valid[tid] = rstn & mn_req_valid & ~full_blk;
    mn_req_ready      = rstn & sn_req_ready[tid] & ~full_blk;
    for (int i = 0; i < SLV_NUM; i++) sn_req[i] = mn_req;
  end

  // Response mux: only the slave at the FIFO head may talk; others are held off.
  always_comb begin
    mn_resp_valid = 1'b0;
    mn_resp       = '0;
    sn_resp_ready = '0;
    if (!empty) begin
      mn_resp             = sn_resp[head];
      mn_resp_valid       = rstn & sn_resp_valid[head];
      sn_resp_ready[head] = rstn & mn_resp_ready;
    end
  end

  imem_noc_router_1ton_tid_fifo #(
    .W     (SLV_IDX_W),
    .DEPTH (OST_DEPTH)
  ) u_tid_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (tid),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .cnt       (ost_cnt)
  );

endmodule

// File: tb/tb_imem_noc_router_1ton.sv
// Self-checking bench for imem_noc_router_1ton against a transaction-level model.
module tb_imem_noc_router_1ton;
  import imem_noc_router_1ton_pkg::*;

  localparam int NS  = 4;
  localparam int OST = 4;

  logic            clk;
  logic            rstn;
  logic            mn_req_valid;
  logic            mn_req_ready;
  mem_req_t        mn_req;
  logic            mn_resp_valid;
  logic            mn_resp_ready;
  mem_resp_t       mn_resp;
  logic [NS-1:0]   sn_req_valid;
  logic [NS-1:0]   sn_req_ready;
  mem_req_t [NS-1:0] sn_req;
  logic [NS-1:0]   sn_resp_valid;
  logic [NS-1:0]   sn_resp_ready;
  mem_resp_t [NS-1:0] sn_resp;
  logic [1:0]      sn_tid;
  logic [2:0]      ost_cnt;

  imem_noc_router_1ton dut (
    .clk           (clk),
    .rstn          (rstn),
    .mn_req_valid  (mn_req_valid),
    .mn_req_ready  (mn_req_ready),
    .mn_req        (mn_req),
    .mn_resp_valid (mn_resp_valid),
    .mn_resp_ready (mn_resp_ready),
    .mn_resp       (mn_resp),
    .sn_req_valid  (sn_req_valid),
    .sn_req_ready  (sn_req_ready),
    .sn_req        (sn_req),
    .sn_resp_valid (sn_resp_valid),
    .sn_resp_ready (sn_resp_ready),
    .sn_resp       (sn_resp),
    .sn_tid        (sn_tid),
    .ost_cnt       (ost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];                       // target of every accepted, unretired request
  int tag_of [NS] = '{0, 1, 2, 3};   // tag table of slaves 0..3
  int got[$];
  int order_exp [3] = '{2, 0, 1};
  int tags3 [3] = '{2, 0, 1};
  int head_s;
  int beat;
  bit hs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_route(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if (int'(a[31:28]) == tag_of[i]) return i;
    return NS - 1;
  endfunction

  task automatic idle();
    mn_req_valid  = 1'b0;
    mn_req        = '0;
    sn_req_ready  = '0;
    sn_resp_valid = '0;
    sn_resp       = '0;
    mn_resp_ready = 1'b0;
  endtask

  // Check every output against the model, then advance one clock.
  task automatic tick();
    int tid, hd;
    bit ne, e_resp_v, e_pop, e_blk, e_req_r, e_push;
    logic [NS-1:0] e_req_v, e_resp_r;
    mem_resp_t e_resp;
    #1;
    tid = ref_route(mn_req.req_addr);
    ne  = (exp_q.size() > 0);
    hd  = ne ? exp_q[0] : 0;
    if (!rstn) begin
      chk("rst_mn_req_ready",  64'(mn_req_ready),  64'(0));
      chk("rst_sn_req_valid",  64'(sn_req_valid),  64'(0));
      chk("rst_mn_resp_valid", 64'(mn_resp_valid), 64'(0));
      chk("rst_sn_resp_ready", 64'(sn_resp_ready), 64'(0));
      @(posedge clk);
      exp_q.delete();
      #1;
      return;
    end
    e_resp_v = ne && sn_resp_valid[hd];
    e_resp   = ne ? sn_resp[hd] : '0;
    e_resp_r = (ne && mn_resp_ready) ? NS'(1 << hd) : '0;
    e_pop    = e_resp_v && mn_resp_ready && e_resp.resp_last;
    e_blk    = (exp_q.size() == OST) && !e_pop;
    e_req_r  = sn_req_ready[tid] && !e_blk;
    e_req_v  = (mn_req_valid && !e_blk) ? NS'(1 << tid) : '0;
    e_push   = mn_req_valid && e_req_r;
    chk("ost_cnt",       64'(ost_cnt),       64'(exp_q.size()));
    chk("sn_tid",        64'(sn_tid),        64'(tid));
    chk("sn_req_valid",  64'(sn_req_valid),  64'(e_req_v));
    chk("mn_req_ready",  64'(mn_req_ready),  64'(e_req_r));
    chk("sn_req_bcast",  64'(sn_req[tid]),   64'(mn_req));
    chk("mn_resp_valid", 64'(mn_resp_valid), 64'(e_resp_v));
    chk("mn_resp",       64'(mn_resp),       64'(e_resp));
    chk("sn_resp_ready", 64'(sn_resp_ready), 64'(e_resp_r));
    @(posedge clk);
    if (e_pop) void'(exp_q.pop_front());
    if (e_push) exp_q.push_back(tid);
    #1;
  endtask

  initial begin
    // Reset with every input asserted: all handshake outputs stay low.
    idle();
    rstn          = 1'b0;
    mn_req_valid  = 1'b1;
    sn_req_ready  = '1;
    sn_resp_valid = '1;
    mn_resp_ready = 1'b1;
    tick();
    tick();
    rstn = 1'b1;
    idle();
    #1 chk("reset_ost_cnt", 64'(ost_cnt), 64'(0));
    tick();

    // Single-beat transaction to slave 1.
    mn_req_valid    = 1'b1;
    mn_req.req_addr = 32'h1000_0000;
    sn_req_ready    = '1;
    #1 chk("single_sn_req_valid", 64'(sn_req_valid), 64'(4'b0010));
    tick();
    mn_req_valid = 1'b0;
    chk("single_ost_1", 64'(ost_cnt), 64'(1));
    sn_resp[1]    = '{resp_data: $urandom, resp_err: 1'b0, resp_last: 1'b1};
    sn_resp_valid = 4'b0010;
    mn_resp_ready = 1'b1;
    #1 chk("single_mn_resp", 64'(mn_resp), 64'(sn_resp[1]));
    tick();
    chk("single_ost_0", 64'(ost_cnt), 64'(0));
    idle();

    // Unmatched tag falls to slave 3, which holds off the master.
    mn_req_valid    = 1'b1;
    mn_req.req_addr = {4'hF, 28'($urandom)};
    sn_req_ready    = 4'b0111;
    #1 chk("unmatched_tid", 64'(sn_tid), 64'(3));
    chk("unmatched_ready", 64'(mn_req_ready), 64'(0));
    tick();
    tick();
    idle();

    // Ordering: tags 2,0,1; slave 0 answers first but must wait for slave 2.
    sn_req_ready = '1;
    mn_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mn_req.req_addr = {4'(tags3[i]), 28'($urandom)};
      tick();
    end
    mn_req_valid = 1'b0;
    for (int s = 0; s < NS; s++)
      sn_resp[s] = '{resp_data: 32'(s), resp_err: 1'b0, resp_last: 1'b1};
    sn_resp_valid = 4'b0001;
    mn_resp_ready = 1'b1;
    #1 chk("order_stall_ready0", 64'(sn_resp_ready[0]), 64'(0));
    chk("order_stall_valid", 64'(mn_resp_valid), 64'(0));
    tick();
    tick();
    sn_resp_valid = 4'b0111;
    got.delete();
    for (int k = 0; k < 8 && got.size() < 3; k++) begin
      #1;
      if (mn_resp_valid) got.push_back(int'(mn_resp.resp_data));
      tick();
    end
    chk("order_count", 64'(got.size()), 64'(3));
    for (int i = 0; i < 3; i++)
      chk("order_seq", 64'((i < got.size()) ? got[i] : -1), 64'(order_exp[i]));
    idle();

    // Full: four outstanding block a fifth until a last beat retires in the same cycle.
    sn_req_ready = '1;
    mn_req_valid = 1'b1;
    for (int i = 0; i < OST; i++) begin
      mn_req.req_addr = {4'($urandom_range(3)), 28'($urandom)};
      tick();
    end
    mn_req.req_addr = {4'($urandom_range(15)), 28'($urandom)};
    #1 chk("full_blocked", 64'(mn_req_ready), 64'(0));
    tick();
    head_s = exp_q[0];
    sn_resp[head_s] = '{resp_data: $urandom, resp_err: 1'b0, resp_last: 1'b1};
    sn_resp_valid   = NS'(1 << head_s);
    mn_resp_ready   = 1'b1;
    #1 chk("full_pop_accept", 64'(mn_req_ready), 64'(1));
    tick();
    chk("full_ost_stays", 64'(ost_cnt), 64'(4));
    idle();

    // Burst: four beats with a toggling master ready; only the last beat retires.
    head_s = exp_q[0];
    beat   = 0;
    got.delete();
    for (int k = 0; k < 40 && beat < 4; k++) begin
      mn_resp_ready   = (k % 2 == 1);
      sn_resp_valid   = NS'(1 << head_s);
      sn_resp[head_s] = '{resp_data: 32'(32'hB0 + beat), resp_err: 1'b0, resp_last: (beat == 3)};
      #1;
      hs = mn_resp_valid && mn_resp_ready;
      if (hs) got.push_back(int'(mn_resp.resp_data));
      tick();
      if (hs) beat++;
    end
    chk("burst_beats", 64'(got.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      chk("burst_data", 64'((i < got.size()) ? got[i] : -1), 64'(32'hB0 + i));
    chk("burst_ost", 64'(ost_cnt), 64'(3));
    idle();

    // Reset with three outstanding drops them; first request afterwards routes normally.
    rstn          = 1'b0;
    mn_req_valid  = 1'b1;
    sn_req_ready  = '1;
    sn_resp_valid = '1;
    mn_resp_ready = 1'b1;
    tick();
    rstn         = 1'b1;
    mn_req_valid = 1'b0;
    #1 chk("rst_mid_ost", 64'(ost_cnt), 64'(0));
    chk("rst_mid_resp_valid", 64'(mn_resp_valid), 64'(0));
    tick();
    mn_req_valid    = 1'b1;
    mn_req.req_addr = {4'h2, 28'($urandom)};
    #1 chk("post_rst_route", 64'(sn_req_valid), 64'(4'b0100));
    tick();
    idle();
    tick();

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rstn            = ($urandom_range(99) != 0);
      mn_req_valid    = ($urandom_range(3) != 0);
      mn_req.req_addr = $urandom;
      sn_req_ready    = NS'($urandom);
      for (int s = 0; s < NS; s++)
        sn_resp[s] = '{resp_data: $urandom, resp_err: 1'($urandom),
                       resp_last: ($urandom_range(2) == 0)};
      sn_resp_valid   = NS'($urandom);
      mn_resp_ready   = ($urandom_range(3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
